// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (3-sample majority vote, runtime parity/stop config) feeding a show-ahead status-tagged RX FIFO.
// Define UART_RX_BREAK_DETECT_EN to add break detection (break_det output, BREAK state).
module uart_rx_fifo #(
    parameter int DATABITS   = 8,
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_line,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    input  logic                        rd_en,
    output logic                        rx_valid,
    output logic [DATABITS-1:0]         rx_data,
    output logic                        parity_error,
    output logic                        frame_error,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                        break_det,
`endif
    output logic                        overrun
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int EW = DATABITS + 2;
    localparam logic [CW-1:0] C_V0  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] C_V1  = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] C_V2  = CW'(BAUD_DIV / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATABITS - 1);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] PUSH   = 3'd5;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] BREAK  = 3'd6;
`endif

    logic [1:0]          sync_q;
    logic                prev_q, rxs, vote, vote_at, bit_end, push, pop, wr;
    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          v_q, v_d;
    logic [3:0]          bit_q, bit_d;
    logic                stop_q, stop_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                par_en_q, par_en_d, odd_q, odd_d, stop2_q, stop2_d;
    logic [DATABITS-1:0] data_q, data_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0]       count_q, count_d;
    logic                ovr_q, ovr_d;

    assign rxs = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_line};
            prev_q <= sync_q[1];
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q, zero_d, brk_q;
    // Tracks whether every vote since the start bit has been 0.
    always_comb zero_d = (state_q == IDLE) ? 1'b1 :
                         (vote_at && state_q inside {DATA, PARITY, STOP}) ? zero_q & ~vote : zero_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b1;
            brk_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            brk_q  <= state_q == PUSH && zero_q;
        end
    end
    assign break_det = brk_q;
    assign push      = state_q == PUSH && !zero_q;
`else
    assign push = state_q == PUSH;
`endif

    always_comb begin
        vote     = (v_q[0] & v_q[1]) | (rxs & (v_q[0] | v_q[1]));
        vote_at  = cnt_q == C_V2;
        bit_end  = cnt_q == C_END;
        cnt_d    = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        v_d      = {cnt_q == C_V1 ? rxs : v_q[1], cnt_q == C_V0 ? rxs : v_q[0]};
        state_d  = state_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        data_d   = data_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        par_en_d = par_en_q;
        odd_d    = odd_q;
        stop2_d  = stop2_q;
        case (state_q)
            IDLE: if (prev_q && !rxs) begin
                state_d  = START;
                par_en_d = parity_mode == 2'b01 || parity_mode == 2'b10;
                odd_d    = parity_mode == 2'b10;
                stop2_d  = stop2;
                bit_d    = '0;
                stop_d   = 1'b0;
                perr_d   = 1'b0;
                ferr_d   = 1'b0;
            end
            START: state_d = (vote_at && vote) ? IDLE : bit_end ? DATA : START;
            DATA: begin
                if (vote_at) data_d = {vote, data_q[DATABITS-1:1]};
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (vote_at) perr_d = ^data_q ^ vote ^ odd_q;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Push right after the last stop vote so a back-to-back start edge is not missed.
                if (vote_at) begin
                    ferr_d = ferr_q | ~vote;
                    if (stop_q == stop2_q) state_d = PUSH;
                end
                if (bit_end) stop_d = 1'b1;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            PUSH:  state_d = zero_q ? BREAK : IDLE;
            BREAK: state_d = rxs ? IDLE : BREAK;
`else
            PUSH:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = rd_en && count_q != '0;
        wr      = push && (count_q != FULL || pop);
        ovr_d   = push && count_q == FULL && !pop;
        count_d = count_q + NW'(wr) - NW'(pop);
        wp_d    = wp_q + AW'(wr);
        rp_d    = rp_q + AW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            v_q      <= 2'b11;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            stop2_q  <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            v_q      <= v_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            par_en_q <= par_en_d;
            odd_q    <= odd_d;
            stop2_q  <= stop2_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            if (wr) mem_q[wp_q] <= {ferr_q, perr_q, data_q};
        end
    end

    assign rx_valid   = count_q != '0;
    assign {frame_error, parity_error, rx_data} = mem_q[rp_q];
    assign fifo_count = count_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames checked against a queue-based FIFO model every cycle, plus literal expectations.
module tb_uart_rx_fifo;
    localparam int FD = 4;
    logic       clk = 1'b0, reset = 1'b1, rx_line = 1'b1, stop2 = 1'b0, rd_en = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       rx_valid, parity_error, frame_error, overrun;
    logic [7:0] rx_data;
    logic [2:0] fifo_count;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       break_det;
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATABITS(8), .BAUD_DIV(16), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .rx_line(rx_line), .parity_mode(parity_mode), .stop2(stop2),
        .rd_en(rd_en), .rx_valid(rx_valid), .rx_data(rx_data), .parity_error(parity_error),
        .frame_error(frame_error), .fifo_count(fifo_count),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det(break_det),
`endif
        .overrun(overrun)
    );

    typedef struct {int t; logic [9:0] e; bit brk;} arr_t;
    arr_t       pend[$];
    logic [9:0] exp_q[$];
    logic       ovr_exp = 1'b0, brk_exp = 1'b0, done = 1'b0;
    int         cyc = 0, n_chk = 0, n_pass = 0, ovr_cnt = 0, brk_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Sends one frame; the expected entry is decoded from the sent bits and scheduled
    // to land 2 cycles after the last stop-bit vote (mid-bit, behind the 2-flop synchroniser).
    task automatic frame(input logic [7:0] d, input logic pb, input logic s1, input logic s2b,
                         input int gbit, input bit pop_arr);
        logic [12:0] b;
        logic [9:0]  e;
        logic        hp;
        int          n, t0;
        hp = parity_mode == 2'b01 || parity_mode == 2'b10;
        b = '1;
        b[0] = 1'b0;
        b[8:1] = d;
        n = 9;
        if (hp) begin b[n] = pb; n++; end
        b[n] = s1; n++;
        if (stop2) begin b[n] = s2b; n++; end
        e = {~s1 | (stop2 & ~s2b), hp & (^d ^ pb ^ (parity_mode == 2'b10)), d};
        @(posedge clk); #1;
        t0 = cyc;
        pend.push_back('{t0 + 16 * (n - 1) + 14, e, 1'b0});
        fork
            for (int i = 0; i < n; i++) begin
                rx_line = b[i];
                if (i == gbit) begin
                    repeat (9) @(posedge clk);
                    #1 rx_line = ~b[i];
                    @(posedge clk);
                    #1 rx_line = b[i];
                    repeat (6) @(posedge clk);
                    #1;
                end else begin
                    repeat (16) @(posedge clk);
                    #1;
                end
            end
            if (pop_arr) begin
                repeat (16 * (n - 1) + 13) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        rx_line = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    initial begin
        fork
            while (!done) begin : model
                logic popd, full;
                arr_t a;
                @(posedge clk);
                cyc++;
                ovr_exp = 1'b0;
                brk_exp = 1'b0;
                if (reset) begin
                    exp_q.delete();
                    pend.delete();
                end else begin
                    popd = rd_en && exp_q.size() > 0;
                    full = exp_q.size() == FD;
                    if (popd) void'(exp_q.pop_front());
                    if (pend.size() > 0 && pend[0].t == cyc) begin
                        a = pend.pop_front();
                        if (a.brk) brk_exp = 1'b1;
                        else if (full && !popd) ovr_exp = 1'b1;
                        else exp_q.push_back(a.e);
                    end
                end
            end
            while (!done) begin : compare
                @(negedge clk);
                ovr_cnt += int'(overrun);
`ifdef UART_RX_BREAK_DETECT_EN
                brk_cnt += int'(break_det);
`endif
                if (!reset) begin
                    chk("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
                    chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
                    chk("overrun", 32'(overrun), 32'(ovr_exp));
`ifdef UART_RX_BREAK_DETECT_EN
                    chk("break_det", 32'(break_det), 32'(brk_exp));
`endif
                    if (exp_q.size() != 0) begin
                        chk("rx_data", 32'(rx_data), 32'(exp_q[0][7:0]));
                        chk("parity_error", 32'(parity_error), 32'(exp_q[0][8]));
                        chk("frame_error", 32'(frame_error), 32'(exp_q[0][9]));
                    end
                end
            end
            begin : stimulus
                int base, t0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("rst rx_valid", 32'(rx_valid), 32'h0);
                chk("rst rx_data", 32'(rx_data), 32'h0);
                chk("rst parity_error", 32'(parity_error), 32'h0);
                chk("rst frame_error", 32'(frame_error), 32'h0);
                chk("rst fifo_count", 32'(fifo_count), 32'h0);
                chk("rst overrun", 32'(overrun), 32'h0);
                @(posedge clk); #1 reset = 1'b0;
                repeat (20) @(posedge clk);
                #1 parity_mode = 2'b01;
                frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b0);
                @(negedge clk);
                chk("even A5 valid", 32'(rx_valid), 32'h1);
                chk("even A5 data", 32'(rx_data), 32'hA5);
                chk("even A5 perr", 32'(parity_error), 32'h0);
                chk("even A5 ferr", 32'(frame_error), 32'h0);
                pop();
                @(negedge clk);
                chk("pop A5 valid", 32'(rx_valid), 32'h0);
                chk("pop A5 count", 32'(fifo_count), 32'h0);
                parity_mode = 2'b10;
                frame(8'h55, 1'b0, 1'b1, 1'b1, -1, 1'b0);
                @(negedge clk);
                chk("odd 55 data", 32'(rx_data), 32'h55);
                chk("odd 55 perr", 32'(parity_error), 32'h1);
                chk("odd 55 ferr", 32'(frame_error), 32'h0);
                pop();
                stop2 = 1'b1;
                frame(8'h55, 1'b0, 1'b1, 1'b0, -1, 1'b0);
                @(negedge clk);
                chk("stop2 ferr", 32'(frame_error), 32'h1);
                chk("stop2 perr", 32'(parity_error), 32'h1);
                pop();
                stop2 = 1'b0;
                parity_mode = 2'b00;
                base = ovr_cnt;
                for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b1, 1'b1, -1, 1'b0);
                @(negedge clk);
                chk("full count", 32'(fifo_count), 32'h4);
                chk("overrun pulses", 32'(ovr_cnt - base), 32'h1);
                chk("full head", 32'(rx_data), 32'h01);
                frame(8'h06, 1'b0, 1'b1, 1'b1, -1, 1'b1);
                @(negedge clk);
                chk("push+pop full count", 32'(fifo_count), 32'h4);
                chk("push+pop no overrun", 32'(ovr_cnt - base), 32'h1);
                chk("pop order 02", 32'(rx_data), 32'h02); pop(); @(negedge clk);
                chk("pop order 03", 32'(rx_data), 32'h03); pop(); @(negedge clk);
                chk("pop order 04", 32'(rx_data), 32'h04); pop(); @(negedge clk);
                chk("pop order 06", 32'(rx_data), 32'h06); pop(); @(negedge clk);
                pop();
                @(negedge clk);
                chk("rd_en empty count", 32'(fifo_count), 32'h0);
                @(posedge clk); #1 rx_line = 1'b0;
                repeat (3) @(posedge clk);
                #1 rx_line = 1'b1;
                repeat (192) @(posedge clk);
                @(negedge clk);
                chk("glitch no push", 32'(fifo_count), 32'h0);
                frame(8'h3C, 1'b0, 1'b1, 1'b1, 3, 1'b0);
                @(negedge clk);
                chk("vote 3C data", 32'(rx_data), 32'h3C);
                pop();
                @(posedge clk); #1 rx_line = 1'b0;
                repeat (32) @(posedge clk);
                #1 rx_line = 1'b1;
                repeat (24) @(posedge clk);
                #1 reset = 1'b1;
                repeat (5) @(posedge clk);
                #1 reset = 1'b0;
                repeat (40) @(posedge clk);
                frame(8'h81, 1'b0, 1'b1, 1'b1, -1, 1'b0);
                @(negedge clk);
                chk("after reset count", 32'(fifo_count), 32'h1);
                chk("after reset data", 32'(rx_data), 32'h81);
                pop();
                base = brk_cnt;
                @(posedge clk); #1 rx_line = 1'b0;
                t0 = cyc;
                pend.push_back('{t0 + 16 * 9 + 14, 10'h200, BRK});
                repeat (480) @(posedge clk);
                #1 rx_line = 1'b1;
                repeat (40) @(posedge clk);
                @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
                chk("break pulses", 32'(brk_cnt - base), 32'h1);
                chk("break count", 32'(fifo_count), 32'h0);
`else
                chk("break as data count", 32'(fifo_count), 32'h1);
                chk("break as data", 32'(rx_data), 32'h00);
                chk("break as data ferr", 32'(frame_error), 32'h1);
                pop();
`endif
                frame(8'h42, 1'b0, 1'b1, 1'b1, -1, 1'b0);
                @(negedge clk);
                chk("post break data", 32'(rx_data), 32'h42);
                chk("post break count", 32'(fifo_count), 32'h1);
                pop();
                repeat (5) @(posedge clk);
                done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
